restoring_divider_16bit: RTL and testbench



---
 rtl/restoring_divider_16bit.sv | 98 +++++++++
 tb/tb_restoring_divider_16bit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_16bit.sv
// 16-bit unsigned restoring divider: one quotient bit per clock via a 17-bit
// trial subtraction, behind a start/busy/done handshake.
module restoring_divider_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [15:0] r;
    logic [15:0] q;
    logic [15:0] d;
    logic [4:0]  cnt;

    logic [16:0] r_shift;
    logic [16:0] trial;
    logic [15:0] r_next;
    logic [15:0] q_next;

    // R stays below D between iterations, so its 17th bit is always zero and
    // only the low 16 bits are stored.
    always_comb begin
        r_shift = {r, q[15]};
        trial   = r_shift + {1'b1, ~d} + 17'd1;
        r_next  = trial[16] ? r_shift[15:0] : trial[15:0];
        q_next  = {q[14:0], ~trial[16]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                // The edge leaving DONE may already accept the next request,
                // giving back-to-back throughput of one operation per 17 cycles.
                IDLE, DONE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            r     <= '0;
                            q     <= dividend;
                            d     <= divisor;
                            cnt   <= '0;
                            done  <= 1'b0;
                            state <= RUN;
                        end
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_16bit.sv
// Directed bench for restoring_divider_16bit: expected results are queued at
// request time and compared when done is observed.
module tb_restoring_divider_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    restoring_divider_16bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a request, push its expected result; returns one sample after the accept edge.
    task automatic drive_req(input logic [15:0] dvd, input logic [15:0] dvs, input bit hold);
        exp_t e;
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        if (dvs == 16'd0) begin
            e.q = 16'hFFFF; e.r = dvd; e.dbz = 1'b1;
        end else begin
            e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    // Count edges until done is seen (bounded), and busy samples before done.
    task automatic wait_done(output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, e.q});
            check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, e.r});
            check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
    endtask

    initial begin
        int lat;
        int nbusy;
        int ndone;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100 / 7 with a one-cycle start pulse
        drive_req(16'd100, 16'd7, 1'b0);
        wait_done(lat, nbusy);
        check("d100_latency", lat, 16);
        check("d100_busy_cycles", nbusy, 16);
        check_result("d100");
        @(posedge clk); #1;
        check("d100_done_single", {31'd0, done}, 32'd0);
        check("d100_busy_after", {31'd0, busy}, 32'd0);

        // FFFF/1 then FFFF/FFFF back to back with start held
        drive_req(16'hFFFF, 16'd1, 1'b1);
        wait_done(lat, nbusy);
        check("ffff1_latency", lat, 16);
        check_result("ffff1");
        drive_req(16'hFFFF, 16'hFFFF, 1'b0);
        check("b2b_done_dropped", {31'd0, done}, 32'd0);
        check("b2b_busy_held", {31'd0, busy}, 32'd1);
        wait_done(lat, nbusy);
        check("b2b_done_spacing", lat + 1, 17);
        check_result("ffffffff");
        @(posedge clk); #1;

        // small and zero dividends
        drive_req(16'd3, 16'd10, 1'b0);
        wait_done(lat, nbusy);
        check("d3_latency", lat, 16);
        check_result("d3");
        @(posedge clk); #1;
        drive_req(16'd0, 16'd5, 1'b0);
        wait_done(lat, nbusy);
        check_result("d0");
        @(posedge clk); #1;

        // divide by zero, then an immediate normal request
        drive_req(16'd5, 16'd0, 1'b0);
        wait_done(lat, nbusy);
        check("dz_latency", lat, 0);
        check("dz_busy", {31'd0, busy}, 32'd1);
        check_result("dz");
        drive_req(16'd9, 16'd3, 1'b0);
        wait_done(lat, nbusy);
        check("d9_latency", lat, 16);
        check_result("d9");
        @(posedge clk); #1;

        // start during RUN must be ignored, operands may change freely
        drive_req(16'd1000, 16'd9, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, nbusy);
        check("d1000_latency", lat + 5, 16);
        check_result("d1000");
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("d1000_extra_done", ndone, 0);

        // reset mid-RUN
        start = 1'b1; dividend = 16'd40000; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_quotient", {16'd0, quotient}, 32'd0);
        check("mrst_remainder", {16'd0, remainder}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("mrst_no_done", ndone, 0);
        drive_req(16'd40000, 16'd3, 1'b0);
        wait_done(lat, nbusy);
        check("d40000_latency", lat, 16);
        check_result("d40000");
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
